phy_rx_decoder: RTL and testbench
=================================

Name: phy_rx_decoder

Overview:
- Receive-side stage between the PHY deserializer and the switch ingress port.
- Accepts 50-bit encoded words from the PHY and strips and checks the framing.
- Buffers valid flits in a small FIFO and presents them to the switch with data_ready/buffer_full flow control.
- Drops malformed words and reports them through error pulses and a saturating error counter.

Parameters:
- FLIT_W, 32: width of decoded flit_t payload.
- DEPTH, 4: FIFO entries, power of two, minimum 2.
- ERR_CNT_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- phy_data_ready  in  1  PHY presents a valid encoded word.
- phy_encoded_flit  in  50  encoded word.
- phy_buffer_full  out  1  back-pressure to the PHY.
- sw_buffer_full  in  1  switch cannot accept a flit.
- sw_data_ready  out  1  flit valid toward the switch.
- sw_flit  out  FLIT_W  decoded flit.
- err_hdr  out  1  one-cycle pulse on a bad sync header.
- err_crc  out  1  one-cycle pulse on a CRC mismatch.
- err_seq  out  1  one-cycle pulse on a sequence gap.
- err_count  out  ERR_CNT_W  saturating total of all errors.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Encoded word layout:
  - [49:48] sync header: 2'b01 = data, 2'b10 = control/idle.
  - [47:44] sequence number.
  - [43:40] reserved, ignored.
  - [39:32] CRC-8.
  - [31:0] flit.
- CRC-8: polynomial 0x07, init 0x00, no reflection, no final XOR, computed MSB-first over [31:0].
- Input acceptance: a word is accepted on a cycle where phy_data_ready=1 and phy_buffer_full=0. A word presented while phy_buffer_full=1 is ignored; it is not an error.
- Stage 1: an accepted word is registered (s1_valid, s1_word).
- Stage 2 (next cycle): checks are applied to s1_word in this priority order:
  1. Header 2'b10: discard silently; no error; sequence not advanced.
  2. Header 2'b00 or 2'b11: discard; pulse err_hdr.
  3. CRC mismatch: discard; pulse err_crc.
  4. Otherwise: push the flit into the FIFO; perform the sequence check.
- At most one err_* pulse per word.
- Sequence check:
  - expected_seq resets to 0.
  - On push, if seq != expected_seq, pulse err_seq; the flit is still delivered.
  - After every push, expected_seq = seq+1 mod 16, which resynchronises the check.
- err_count increments by 1 on any err_* pulse and saturates at all-ones.
- Latency: a word accepted in cycle N is pushed at the end of cycle N+1. sw_data_ready is asserted in cycle N+2 if the FIFO was empty.
- Output handshake:
  - A flit leaves the FIFO on a cycle where sw_data_ready=1 and sw_buffer_full=0.
  - sw_data_ready = FIFO not empty; sw_flit = head entry.
  - sw_flit must not change while sw_data_ready=1 and sw_buffer_full=1.
- Back-pressure: phy_buffer_full = (fifo_count + s1_valid) >= DEPTH, derived from registered state only. This guarantees no overflow. The FIFO is never written when full.
- Simultaneous push and pop on a full FIFO is legal; the count is unchanged.
- Pointers wrap modulo DEPTH. Maximum throughput is one flit per cycle when there is no back-pressure.
- Reset values:
  - FIFO, count and pointers cleared; s1_valid=0; expected_seq=0.
  - sw_data_ready=0, sw_flit=0, phy_buffer_full=0.
  - All err_* =0, err_count=0.
- Reset asserted mid-stream discards all buffered and in-flight words.

Optional Feature:
- Macro PHY_RX_SEQ_CHECK_EN.
- Defined: sequence check as above.
- Undefined: the sequence field is ignored, expected_seq logic is removed, and err_seq is tied to 0. err_count then counts only header and CRC errors.

Test Plan:
- Reset, then send header 01, seq 0, CRC 0x00, flit 0x00000000 with sw_buffer_full=0 -> sw_data_ready=1 two cycles later with sw_flit=0x00000000; no error pulses.
- Send seq 1, CRC 0x07, flit 0x00000001, then the same word with CRC 0x06 -> first delivered; second dropped with one err_crc pulse and err_count=1.
- Hold sw_buffer_full=1 and stream DEPTH+2 valid words -> phy_buffer_full asserts once 4 words are buffered or in flight, and no word is lost. Release -> the 4 flits exit in order, one per cycle.
- Send seq 0 then seq 3 (valid CRC) -> both delivered; err_seq pulses on the second. Then seq 4 -> no err_seq.
- Send header 2'b10 then header 2'b11 -> no output; err_hdr pulses exactly once; err_count increments by 1.
- Force 256 CRC errors with ERR_CNT_W=8 -> err_count saturates at 0xFF. Then assert rst mid-stream -> all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/phy_rx_decoder.sv
// phy_rx_decoder: PHY word framing/CRC check into a flit FIFO with error reporting; PHY_RX_SEQ_CHECK_EN enables the sequence check
module phy_rx_decoder #(
  parameter int FLIT_W = 32,
  parameter int DEPTH = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 phy_data_ready,
  input  logic [49:0]          phy_encoded_flit,
  output logic                 phy_buffer_full,
  input  logic                 sw_buffer_full,
  output logic                 sw_data_ready,
  output logic [FLIT_W-1:0]    sw_flit,
  output logic                 err_hdr,
  output logic                 err_crc,
  output logic                 err_seq,
  output logic [ERR_CNT_W-1:0] err_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic s1_valid;
  logic [49:0] s1_word;
  logic [FLIT_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic accept, push, pop, hdr_bad, crc_bad, seq_bad, any_err;
  function automatic logic [7:0] crc8(input logic [31:0] d);
    logic [7:0] c;
    c = '0;
    for (int i = 31; i >= 0; i--) c = {c[6:0], 1'b0} ^ ((c[7] ^ d[i]) ? 8'h07 : 8'h00);
    return c;
  endfunction
  assign phy_buffer_full = (count + CW'(s1_valid)) >= CW'(DEPTH);
  assign accept = phy_data_ready & ~phy_buffer_full;
  assign hdr_bad = s1_valid & (s1_word[49] == s1_word[48]);
  assign crc_bad = s1_valid & (s1_word[49:48] == 2'b01) & (crc8(s1_word[31:0]) != s1_word[39:32]);
  assign push = s1_valid & (s1_word[49:48] == 2'b01) & ~crc_bad;
  assign any_err = hdr_bad | crc_bad | seq_bad;
  assign sw_data_ready = count != '0;
  assign pop = sw_data_ready & ~sw_buffer_full;
  assign sw_flit = sw_data_ready ? mem[rd_ptr] : '0;
  // Stage 1: capture each accepted PHY word
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_word <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) s1_word <= phy_encoded_flit;
    end
  end
  // Flit FIFO; back-pressure keeps pushes away from a full buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) mem[wr_ptr] <= FLIT_W'(s1_word[31:0]);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  // Registered error pulses and saturating error total
  always_ff @(posedge clk) begin
    if (rst) begin
      err_hdr <= 1'b0;
      err_crc <= 1'b0;
      err_seq <= 1'b0;
      err_count <= '0;
    end else begin
      err_hdr <= hdr_bad;
      err_crc <= crc_bad;
      err_seq <= seq_bad;
      if (any_err && !(&err_count)) err_count <= err_count + ERR_CNT_W'(1);
    end
  end
`ifdef PHY_RX_SEQ_CHECK_EN
  logic [3:0] expected_seq;
  logic unused_bits;
  assign unused_bits = ^s1_word[43:40];
  assign seq_bad = push & (s1_word[47:44] != expected_seq);
  // Expected sequence resyncs to the last pushed word
  always_ff @(posedge clk) begin
    if (rst) expected_seq <= '0;
    else if (push) expected_seq <= s1_word[47:44] + 4'd1;
  end
`else
  logic unused_bits;
  assign unused_bits = ^s1_word[47:40];
  assign seq_bad = 1'b0;
`endif
endmodule

// File: tb/tb_phy_rx_decoder.sv
// tb_phy_rx_decoder: table vectors, corner sequences and random traffic against a queue-based reference model
module tb_phy_rx_decoder;
  localparam int DEPTH = 4;
  localparam int FLIT_W = 32;
  localparam int ERR_CNT_W = 8;
  localparam int ECNT_MAX = (1 << ERR_CNT_W) - 1;
`ifdef PHY_RX_SEQ_CHECK_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic phy_data_ready = 1'b0;
  logic [49:0] phy_encoded_flit = '0;
  logic sw_buffer_full = 1'b0;
  logic phy_buffer_full, sw_data_ready, err_hdr, err_crc, err_seq;
  logic [FLIT_W-1:0] sw_flit;
  logic [ERR_CNT_W-1:0] err_count;
  always #5 clk = ~clk;
  phy_rx_decoder #(.FLIT_W(FLIT_W), .DEPTH(DEPTH), .ERR_CNT_W(ERR_CNT_W)) dut (
    .clk(clk), .rst(rst),
    .phy_data_ready(phy_data_ready), .phy_encoded_flit(phy_encoded_flit),
    .phy_buffer_full(phy_buffer_full),
    .sw_buffer_full(sw_buffer_full), .sw_data_ready(sw_data_ready), .sw_flit(sw_flit),
    .err_hdr(err_hdr), .err_crc(err_crc), .err_seq(err_seq), .err_count(err_count)
  );
  typedef struct { logic [31:0] flit; int rdy_cyc; } ent_t;
  typedef struct {
    logic [1:0] hdr; logic [3:0] seq; logic [7:0] crc; logic [31:0] flit;
    logic deliver; logic [2:0] err;
  } vec_t;
  ent_t fq[$];
  logic [2:0] exp_err [int];
  vec_t tbl [12];
  int cyc = 0;
  int last_acc = -10;
  int ecnt = 0;
  logic [3:0] eseq = 4'd0;
  int n_chk = 0;
  int n_err = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask
  // CRC-8 as the remainder of flit*x^8 divided by x^8+x^2+x+1
  function automatic logic [7:0] crc_ref(input logic [31:0] f);
    logic [39:0] r;
    r = {f, 8'h00};
    for (int i = 39; i >= 8; i--) if (r[i]) r[i-:9] = r[i-:9] ^ 9'h107;
    return r[7:0];
  endfunction
  function automatic bit m_rdy();
    return fq.size() > 0 && fq[0].rdy_cyc <= cyc;
  endfunction
  function automatic bit m_full();
    int v;
    v = (last_acc == cyc - 1) ? 1 : 0;
    foreach (fq[i]) if (fq[i].rdy_cyc <= cyc) v++;
    return v >= DEPTH;
  endfunction
  task automatic tick_check();
    logic [2:0] e;
    @(negedge clk);
    e = exp_err.exists(cyc) ? exp_err[cyc] : 3'b000;
    if (e != 3'b000 && ecnt < ECNT_MAX) ecnt++;
    chk("sw_data_ready", sw_data_ready, m_rdy());
    chk("phy_buffer_full", phy_buffer_full, m_full());
    chk("err_hdr_crc_seq", {err_hdr, err_crc, err_seq}, e);
    chk("err_count", err_count, ecnt);
    if (m_rdy()) chk("sw_flit", sw_flit, fq[0].flit);
  endtask
  task automatic drive(input bit rdy, input logic [49:0] w, input bit swf, output bit acc);
    ent_t en;
    phy_data_ready = rdy;
    phy_encoded_flit = w;
    sw_buffer_full = swf;
    acc = rdy && !m_full();
    if (m_rdy() && !swf) void'(fq.pop_front());
    if (acc) begin
      last_acc = cyc;
      if (w[49:48] == 2'b01 && crc_ref(w[31:0]) == w[39:32]) begin
        en.flit = w[31:0];
        en.rdy_cyc = cyc + 2;
        fq.push_back(en);
        exp_err[cyc + 2] = {2'b00, SEQ_EN && (w[47:44] != eseq)};
        eseq = w[47:44] + 4'd1;
      end else if (w[49:48] == 2'b01) exp_err[cyc + 2] = 3'b010;
      else if (w[49] == w[48]) exp_err[cyc + 2] = 3'b100;
    end
    cyc++;
  endtask
  task automatic step(input bit rdy, input logic [49:0] w, input bit swf, output bit acc);
    tick_check();
    drive(rdy, w, swf, acc);
  endtask
  task automatic do_reset();
    bit a;
    @(negedge clk);
    rst = 1'b1;
    phy_data_ready = 1'b0;
    sw_buffer_full = 1'b0;
    @(negedge clk);
    chk("rst sw_data_ready", sw_data_ready, 0);
    chk("rst phy_buffer_full", phy_buffer_full, 0);
    chk("rst sw_flit", sw_flit, 0);
    chk("rst err pulses", {err_hdr, err_crc, err_seq}, 0);
    chk("rst err_count", err_count, 0);
    rst = 1'b0;
    fq.delete();
    exp_err.delete();
    last_acc = -10;
    eseq = 4'd0;
    ecnt = 0;
    drive(1'b0, '0, 1'b0, a);
  endtask
  function automatic logic [49:0] mk(input logic [1:0] h, input logic [3:0] s, input logic [7:0] c, input logic [31:0] f);
    return {h, s, 4'($urandom), c, f};
  endfunction
  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1);
  end
  initial begin
    bit a;
    int idx, c0;
    logic [49:0] w;
    logic [49:0] bw [6];
    logic [31:0] f;
    logic [1:0] h;
    logic [3:0] s;
    logic [7:0] c;
    tbl[0]  = '{2'b01, 4'd0, 8'h00, 32'h0000_0000, 1'b1, 3'b000};
    tbl[1]  = '{2'b01, 4'd1, 8'h07, 32'h0000_0001, 1'b1, 3'b000};
    tbl[2]  = '{2'b01, 4'd1, 8'h06, 32'h0000_0001, 1'b0, 3'b010};
    tbl[3]  = '{2'b01, 4'd2, 8'h15, 32'h0000_0100, 1'b1, 3'b000};
    tbl[4]  = '{2'b10, 4'd9, 8'h00, 32'h0000_0000, 1'b0, 3'b000};
    tbl[5]  = '{2'b11, 4'd3, 8'h00, 32'h0000_0000, 1'b0, 3'b100};
    tbl[6]  = '{2'b00, 4'd3, 8'h07, 32'h0000_0001, 1'b0, 3'b100};
    tbl[7]  = '{2'b01, 4'd3, 8'h6B, 32'h0001_0000, 1'b1, 3'b000};
    tbl[8]  = '{2'b01, 4'd7, 8'h00, 32'h0000_0000, 1'b1, 3'b001};
    tbl[9]  = '{2'b01, 4'd8, 8'h07, 32'h0000_0001, 1'b1, 3'b000};
    tbl[10] = '{2'b01, 4'd9, 8'h00, 32'h0000_0001, 1'b0, 3'b010};
    tbl[11] = '{2'b10, 4'd0, 8'h6B, 32'h0000_0000, 1'b0, 3'b000};
    do_reset();
    for (int k = 0; k < 12; k++) begin
      w = mk(tbl[k].hdr, tbl[k].seq, tbl[k].crc, tbl[k].flit);
      step(1'b1, w, 1'b0, a);
      step(1'b0, '0, 1'b0, a);
      tick_check();
      chk("tbl err", {err_hdr, err_crc, err_seq}, tbl[k].err & {2'b11, SEQ_EN});
      chk("tbl deliver", sw_data_ready, tbl[k].deliver);
      if (tbl[k].deliver) chk("tbl flit", sw_flit, tbl[k].flit);
      drive(1'b0, '0, 1'b0, a);
    end
    c0 = ecnt;
    step(1'b1, mk(2'b10, 4'd0, 8'h00, 32'h0), 1'b0, a);
    step(1'b1, mk(2'b11, 4'd0, 8'h00, 32'h0), 1'b0, a);
    for (int t = 0; t < 3; t++) step(1'b0, '0, 1'b0, a);
    chk("hdr pair count", err_count, c0 + 1);
    do_reset();
    for (int k = 0; k < 6; k++) begin
      f = $urandom;
      bw[k] = mk(2'b01, 4'(k), crc_ref(f), f);
    end
    idx = 0;
    for (int t = 0; t < 10; t++) begin
      if (idx < 6) step(1'b1, bw[idx], 1'b1, a);
      else step(1'b0, '0, 1'b1, a);
      if (a) idx++;
    end
    tick_check();
    chk("bp full", phy_buffer_full, 1);
    drive(idx < 6, bw[idx % 6], 1'b0, a);
    if (a) idx++;
    for (int t = 0; t < 12; t++) begin
      if (idx < 6) step(1'b1, bw[idx], 1'b0, a);
      else step(1'b0, '0, 1'b0, a);
      if (a) idx++;
    end
    do_reset();
    for (int t = 0; t < 600; t++) begin
      idx = $urandom_range(0, 19);
      h = (idx == 0) ? 2'b00 : (idx == 1) ? 2'b11 : (idx < 4) ? 2'b10 : 2'b01;
      f = $urandom;
      s = ($urandom_range(0, 9) == 0) ? 4'($urandom) : eseq;
      c = ($urandom_range(0, 9) == 0) ? crc_ref(f) ^ 8'h5A : crc_ref(f);
      step($urandom_range(0, 9) < 7, mk(h, s, c, f), $urandom_range(0, 9) < 3, a);
    end
    for (int t = 0; t < 10; t++) step(1'b0, '0, 1'b0, a);
    do_reset();
    for (int t = 0; t < 262; t++) begin
      f = $urandom;
      step(1'b1, mk(2'b01, 4'd0, ~crc_ref(f), f), 1'b0, a);
    end
    for (int t = 0; t < 3; t++) step(1'b0, '0, 1'b0, a);
    chk("err_count saturated", err_count, 8'hFF);
    for (int t = 0; t < 4; t++) begin
      f = $urandom;
      step(1'b1, mk(2'b01, eseq, crc_ref(f), f), 1'b1, a);
    end
    do_reset();
    for (int t = 0; t < 4; t++) step(1'b0, '0, 1'b0, a);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
